laplace_frame_ctrl: RTL and testbench

LAPLACE_FRAME_CTRL -- requirements
Module: laplace_frame_ctrl

---
 rtl/laplace_frame_ctrl.sv | 173 +++++++++++++++++
 tb/tb_laplace_frame_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/laplace_frame_ctrl.sv
// Laplacian frame controller: raster-scans a frame, fetches the
// 4-neighbour cross per interior pixel and writes the clamped result.
module laplace_frame_ctrl #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    WRITE,
    FIN
  } state_t;

  localparam logic [8:0] XMAX = 9'(IMG_W - 1);
  localparam logic [8:0] YMAX = 9'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ROW = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t state, state_nx;

  logic [8:0]        x, y;
  logic [8:0]        nx, ny;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        phase;
  logic [7:0]        b, d, e, f, h;

  logic              x_last, y_last;
  logic              border, nb;
  logic signed [11:0] lap;
  logic [7:0]        lap_sat;

  // Position bookkeeping for the current and the following pixel
  always_comb begin
    x_last = (x == XMAX);
    y_last = (y == YMAX);
    border = (x == 9'd0) || x_last || (y == 9'd0) || y_last;
    nx     = x_last ? 9'd0 : x + 9'd1;
    ny     = x_last ? y + 9'd1 : y;
    nb     = (nx == 9'd0) || (nx == XMAX) ||
             (ny == 9'd0) || (ny == YMAX);
  end

  // Laplacian of the captured cross, saturated to one byte
  always_comb begin
    lap = $signed({4'b0, b}) + $signed({4'b0, d})
        + $signed({4'b0, f}) + $signed({4'b0, h})
        - $signed({2'b0, e, 2'b0});
    if (lap < 12'sd0)
      lap_sat = 8'd0;
    else if (lap > 12'sd255)
      lap_sat = 8'd255;
    else
      lap_sat = lap[7:0];
  end

  // State register, scan counters and the neighbour holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      addr  <= '0;
      phase <= '0;
      b     <= '0;
      d     <= '0;
      e     <= '0;
      f     <= '0;
      h     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            x     <= '0;
            y     <= '0;
            addr  <= '0;
            phase <= '0;
          end
        end
        FETCH: begin
          phase <= phase + 3'd1;
          case (phase)
            3'd1:    b <= rd_data;
            3'd2:    d <= rd_data;
            3'd3:    e <= rd_data;
            3'd4:    f <= rd_data;
            default: ;
          endcase
        end
        WAIT: begin
          h     <= rd_data;
          phase <= '0;
        end
        WRITE: begin
          x     <= nx;
          y     <= ny;
          addr  <= addr + ONE;
          phase <= '0;
        end
        default: ;
      endcase
    end
  end

  // Next-state selection and memory-port outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    case (state)
      IDLE: begin
        // (0,0) is always a border pixel, so a frame opens with a write
        if (start)
          state_nx = WRITE;
      end
      FETCH: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        case (phase)
          3'd0:    rd_addr = addr - ROW;
          3'd1:    rd_addr = addr - ONE;
          3'd3:    rd_addr = addr + ONE;
          3'd4:    rd_addr = addr + ROW;
          default: rd_addr = addr;
        endcase
        if (phase == 3'd4)
          state_nx = WAIT;
      end
      WAIT: begin
        busy     = 1'b1;
        state_nx = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = border ? 8'd0 : lap_sat;
        if (x_last && y_last)
          state_nx = FIN;
        else if (nb)
          state_nx = WRITE;
        else
          state_nx = FETCH;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_laplace_frame_ctrl.sv
// Directed bench for laplace_frame_ctrl on a 4x4 frame.
// Vector table for the arithmetic, hand sequences for timing corners.
module tb_laplace_frame_ctrl;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done;
  logic          rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [7:0]    rd_data, wr_data;

  logic [7:0] src [16];
  logic [7:0] dst [16];
  int         seq [32];
  logic       ev_rd [64];
  logic       ev_wr [64];
  int         ev_ra [64];
  int         ev_wa [64];

  int n_cmp = 0;
  int n_err = 0;
  int wr_n, done_cnt, done_at, both_hi, busy_cnt;

  typedef struct {
    logic [7:0] c, n, w, e, s, exp;
  } vec_t;

  vec_t vecs [7];

  laplace_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  // Source memory: one-cycle read latency
  always @(posedge clk) rd_data <= src[rd_addr];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) src[i] = v;
  endtask

  task automatic load_cross(input vec_t v);
    fill(8'd0);
    src[5] = v.c;
    src[1] = v.n;
    src[4] = v.w;
    src[6] = v.e;
    src[9] = v.s;
  endtask

  // Runs one frame for 60 cycles, logging every cycle after start
  task automatic run_frame(input int restart_at);
    wr_n = 0; done_cnt = 0; done_at = -1;
    both_hi = 0; busy_cnt = 0;
    for (int i = 0; i < 16; i++) dst[i] = 8'hEE;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start = (n == restart_at);
      ev_rd[n] = rd_en;
      ev_wr[n] = wr_en;
      ev_ra[n] = int'(rd_addr);
      ev_wa[n] = int'(wr_addr);
      if (rd_en && wr_en) both_hi++;
      if (busy) busy_cnt++;
      if (wr_en) begin
        if (wr_n < 32) seq[wr_n] = int'(wr_addr);
        dst[wr_addr] = wr_data;
        wr_n++;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int nz, ord_bad, late_wr, late_done;
    vecs[0] = '{c:50,  n:60,  w:70,  e:80,  s:90,  exp:100};
    vecs[1] = '{c:10,  n:200, w:200, e:200, s:200, exp:255};
    vecs[2] = '{c:255, n:0,   w:0,   e:0,   s:0,   exp:0};
    vecs[3] = '{c:20,  n:10,  w:20,  e:30,  s:40,  exp:20};
    vecs[4] = '{c:0,   n:255, w:0,   e:0,   s:1,   exp:255};
    vecs[5] = '{c:1,   n:3,   w:0,   e:0,   s:0,   exp:0};
    vecs[6] = '{c:63,  n:255, w:0,   e:0,   s:0,   exp:3};

    rst = 1'b1; start = 1'b0;
    fill(8'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);

    // Flat frame: Laplacian is zero everywhere
    fill(8'd100);
    run_frame(0);
    nz = 0;
    for (int i = 0; i < 16; i++) if (dst[i] != 8'd0) nz++;
    chk("t1_writes", wr_n, 16);
    chk("t1_nonzero", nz, 0);
    chk("t1_done_at", done_at, 41);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_cycles", busy_cnt, 40);
    chk("t1_rd_wr_overlap", both_hi, 0);

    // Arithmetic and saturation at pixel (1,1)
    for (int k = 0; k < 7; k++) begin
      load_cross(vecs[k]);
      run_frame(0);
      chk($sformatf("vec%0d_addr5", k), int'(dst[5]), int'(vecs[k].exp));
      chk($sformatf("vec%0d_border0", k), int'(dst[0]), 0);
      chk($sformatf("vec%0d_writes", k), wr_n, 16);
    end

    // Access timing for pixel (1,1)
    load_cross(vecs[0]);
    run_frame(0);
    chk("t4_pre_wr", int'(ev_wr[5]), 1);
    chk("t4_pre_wa", ev_wa[5], 4);
    chk("t4_rd6", ev_rd[6] ? ev_ra[6] : -1, 1);
    chk("t4_rd7", ev_rd[7] ? ev_ra[7] : -1, 4);
    chk("t4_rd8", ev_rd[8] ? ev_ra[8] : -1, 5);
    chk("t4_rd9", ev_rd[9] ? ev_ra[9] : -1, 6);
    chk("t4_rd10", ev_rd[10] ? ev_ra[10] : -1, 9);
    chk("t4_idle_rd", int'(ev_rd[11]), 0);
    chk("t4_idle_wr", int'(ev_wr[11]), 0);
    chk("t4_wr12", ev_wr[12] ? ev_wa[12] : -1, 5);
    chk("t4_wr_data", int'(dst[5]), 100);

    // Start repeated mid-frame must not restart the scan
    run_frame(10);
    ord_bad = 0;
    for (int i = 0; i < 16; i++) if (seq[i] != i) ord_bad++;
    chk("t5_writes", wr_n, 16);
    chk("t5_order", ord_bad, 0);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_done_at", done_at, 41);
    chk("t5_addr5", int'(dst[5]), 100);

    // Reset in cycle 15 aborts the frame
    late_wr = 0; late_done = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 16) begin
        chk("t6_busy", int'(busy), 0);
        chk("t6_wr_en", int'(wr_en), 0);
        rst = 1'b0;
      end
      if (n >= 16 && wr_en) late_wr++;
      if (done) late_done++;
      if (n == 15) rst = 1'b1;
    end
    chk("t6_late_writes", late_wr, 0);
    chk("t6_done", late_done, 0);
    run_frame(0);
    chk("t6_re_writes", wr_n, 16);
    chk("t6_re_done_at", done_at, 41);
    chk("t6_re_addr5", int'(dst[5]), 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
